// File: rtl/n3_coef_loader.sv
// ---------------------------------------------------------------------------
// n3_coef_loader
//
// Streams a sigmoid coefficient table into a RAM. Each segment takes two
// words from the input stream (Ai then Bi) and writes them as one RAM word
// {Ai, Bi} at the segment index. Segments are written at addresses
// 0..NUM_SEG-1 in order. NUM_SEG must not exceed 2**ADDR_WIDTH.
//
// Optional feature: define N3_COEF_CKSUM_EN to expect one extra checksum
// word after the table. That word must equal the XOR of all 2*NUM_SEG data
// words. On a mismatch o_err pulses together with o_done. Without the macro
// no checksum word is read and o_err is always 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_start      start a table load (only honoured while idle)
//   i_data       coefficient stream word
//   i_valid      i_data valid this cycle
//   o_ready      loader accepts i_data this cycle
//   o_coef       RAM write data {Ai, Bi}
//   o_coef_addr  RAM write address (segment index)
//   o_load_coef  RAM write strobe, one cycle per segment
//   o_busy       load in progress (through the o_done cycle)
//   o_done       one-cycle table-complete pulse
//   o_err        one-cycle checksum-mismatch pulse, coincident with o_done
// ---------------------------------------------------------------------------
module n3_coef_loader #(
   parameter int BIT_WIDTH  = 16,
   parameter int NUM_SEG    = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [BIT_WIDTH-1:0]   i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic [2*BIT_WIDTH-1:0] o_coef,
   output logic [ADDR_WIDTH-1:0]  o_coef_addr,
   output logic                   o_load_coef,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

`ifdef N3_COEF_CKSUM_EN
   typedef enum logic [2:0] {IDLE, GET_A, GET_B, WRITE, CHECK, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, GET_A, GET_B, WRITE, DONE} state_t;
`endif

   localparam logic [ADDR_WIDTH-1:0] LAST_SEG = ADDR_WIDTH'(NUM_SEG - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [BIT_WIDTH-1:0]  a_q, a_d;
   logic [BIT_WIDTH-1:0]  b_q, b_d;
   logic                  xfer;

   // The outputs are decoded only from registered state and data. They are
   // therefore glitch-free, and they drop to 0 as soon as rst is asserted.
`ifdef N3_COEF_CKSUM_EN
   assign o_ready = (state_q == GET_A) || (state_q == GET_B) || (state_q == CHECK);
`else
   assign o_ready = (state_q == GET_A) || (state_q == GET_B);
`endif
   assign xfer        = i_valid && o_ready;
   assign o_load_coef = (state_q == WRITE);
   assign o_coef      = {a_q, b_q};
   assign o_coef_addr = cnt_q;
   assign o_busy      = (state_q != IDLE);
   assign o_done      = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = GET_A;
               cnt_d   = '0;
            end
         end
         GET_A: begin
            if (xfer) begin
               a_d     = i_data;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (xfer) begin
               b_d     = i_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The counter stops at the last segment. It never wraps inside a
            // load, so addresses are always strictly ascending.
            if (cnt_q != LAST_SEG) begin
               cnt_d   = cnt_q + ADDR_WIDTH'(1);
               state_d = GET_A;
            end else begin
`ifdef N3_COEF_CKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef N3_COEF_CKSUM_EN
         CHECK: begin
            if (xfer) begin
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            // i_start is deliberately ignored here. A new load starts only
            // after the FSM has returned to IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

`ifdef N3_COEF_CKSUM_EN
   logic [BIT_WIDTH-1:0] xor_q, xor_d;
   logic                 err_q, err_d;

   // The running XOR covers data words only; the checksum word itself is
   // excluded. err_q holds the verdict from CHECK until the DONE cycle.
   always_comb begin
      xor_d = xor_q;
      err_d = err_q;
      if (state_q == IDLE && i_start) begin
         xor_d = '0;
         err_d = 1'b0;
      end else if (xfer && (state_q == GET_A || state_q == GET_B)) begin
         xor_d = xor_q ^ i_data;
      end else if (xfer && state_q == CHECK) begin
         err_d = (i_data != xor_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_q <= '0;
         err_q <= 1'b0;
      end else begin
         xor_q <= xor_d;
         err_q <= err_d;
      end
   end

   assign o_err = o_done && err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: doc/n3_coef_loader.md
N3_COEF_LOADER -- requirements
Module: n3_coef_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of one coefficient word (Ai or Bi).
REQ-002 Parameter NUM_SEG, default 16: number of sigmoid segments to load.
REQ-003 Parameter ADDR_WIDTH, default 4: coefficient RAM address width; NUM_SEG SHALL be at most 2^ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  request to load one full coefficient table.
REQ-007 i_data  in  BIT_WIDTH  coefficient stream word.
REQ-008 i_valid  in  1  i_data is valid this cycle.
REQ-009 o_ready  out  1  loader accepts i_data this cycle.
REQ-010 o_coef  out  2*BIT_WIDTH  RAM write data, {Ai, Bi} with Ai in the upper half.
REQ-011 o_coef_addr  out  ADDR_WIDTH  RAM write address (segment index).
REQ-012 o_load_coef  out  1  RAM write strobe, one cycle per segment.
REQ-013 o_busy  out  1  high from the cycle after i_start is accepted until o_done.
REQ-014 o_done  out  1  one-cycle pulse when the table is complete.
REQ-015 o_err  out  1  one-cycle checksum-mismatch pulse, coincident with o_done.

Function
REQ-016 FSM states SHALL be IDLE, GET_A, GET_B, WRITE, CHECK and DONE, with all outputs decoded from registered state and data.
REQ-017 A transfer SHALL occur only on a cycle with i_valid=1 and o_ready=1; o_ready SHALL be 1 only in GET_A, GET_B and CHECK.
REQ-018 IDLE: i_start=1 -> GET_A with segment counter cleared to 0; i_start SHALL be ignored in every other state.
REQ-019 GET_A: a transfer captures i_data as Ai and moves to GET_B; with no transfer the FSM holds.
REQ-020 GET_B: a transfer captures i_data as Bi and moves to WRITE; with no transfer the FSM holds.
REQ-021 WRITE: o_load_coef=1 for exactly one cycle, with o_coef={Ai,Bi} and o_coef_addr=counter stable in that cycle.
REQ-022 From WRITE, if counter /= NUM_SEG-1, the counter increments and the FSM goes to GET_A; otherwise it goes to CHECK when the macro is defined, else to DONE.
REQ-023 DONE: o_done=1 for one cycle, then IDLE.
REQ-024 Minimum cost per segment is 3 cycles; back-to-back i_valid SHALL never be dropped or duplicated.
REQ-025 Addresses SHALL be written strictly ascending, 0..NUM_SEG-1; the counter SHALL never wrap within a load.
REQ-026 i_start asserted in the DONE cycle SHALL be ignored; a new load requires i_start in IDLE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0 and Ai/Bi registers=0, with o_ready, o_load_coef, o_busy, o_done and o_err all 0 and o_coef and o_coef_addr 0.
REQ-028 Reset mid-load SHALL abort the load without any further o_load_coef; RAM entries already written are left as is.

Configuration
REQ-029 Macro N3_COEF_CKSUM_EN defined: the loader keeps a running BIT_WIDTH XOR of all 2*NUM_SEG data words, cleared on i_start.
REQ-030 In CHECK, one extra word is accepted; if it differs from the running XOR, o_err=1 in the DONE cycle, else o_err=0.
REQ-031 Macro N3_COEF_CKSUM_EN undefined: no CHECK state and no checksum word is consumed; o_err is tied to 0.

Verification
REQ-032 Full load, i_valid held high, with words 0x0100+k for k=0..31 -> 16 strobes at addresses 0..15, where address n receives o_coef={0x0100+2n, 0x0101+2n}; o_done follows 48 cycles after the first transfer (without the macro).
REQ-033 i_valid toggling 1,0,1,0 -> identical RAM contents and strobe count (16), with o_load_coef never asserted while in GET_A or GET_B.
REQ-034 rst pulse after the 5th strobe (address 4) -> all outputs 0 asynchronously, no further strobes; a following i_start reloads from address 0.
REQ-035 i_start pulsed while o_busy=1 -> ignored; exactly 16 strobes and one o_done.
REQ-036 With N3_COEF_CKSUM_EN, a correct XOR word -> o_done=1 with o_err=0; the same XOR^0x0001 -> o_done=1 with o_err=1 in the same cycle.
